// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze sequencer for the 5-stage pipeline
// Control outputs are combinational from state; counters and halted_o are registered.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_noop_o,
  output logic             freeze_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM_WAIT, S_HALT} state_t;

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             load_use;
  logic             freeze_req;

  // x0 is hardwired to zero, so a load into it can never create a hazard
  assign load_use   = idex_memread_i && (idex_rd_i != 5'd0) &&
                      ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
  assign freeze_req = mem_req_i && !mem_ack_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (freeze_req) begin
          state_d = S_MEM_WAIT;
          wait_d  = 8'd1;
        end else if (!start_i) begin
          state_d = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack_i)              state_d = S_RUN;
        else if (wait_q == TIMEOUT) state_d = S_HALT;
        else                        wait_d  = wait_q + 8'd1;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Freeze outranks load-use, which in turn suppresses a branch flush
  always_comb begin
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_noop_o  = 1'b0;
    freeze_o     = 1'b0;
    case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if ((state_q == S_RUN && freeze_req) || (state_q == S_MEM_WAIT && !mem_ack_i)) begin
          freeze_o = 1'b1;
        end else if (load_use) begin
          idex_noop_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = branch_taken_i;
        end
      end
      default: idex_noop_o = 1'b1;
    endcase
  end

  always_comb begin
    stall_d  = stall_q;
    flush_d  = flush_q;
    halted_d = halted_q || (state_q == S_HALT);
    if ((state_q == S_RUN || state_q == S_MEM_WAIT) && !pc_write_o && stall_q != CNT_MAX)
      stall_d = stall_q + CNT_ONE;
    if (ifid_flush_o && flush_q != CNT_MAX)
      flush_d = flush_q + CNT_ONE;
  end

  assign halted_o    = halted_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/freeze sequencer for the 5-stage pipeline. Sits beside the ID/EX pipeline register.
- Detects load-use hazards, which insert a NoOp bubble into ID/EX and hold PC and IF/ID.
- Applies taken-branch flushes to IF/ID.
- Freezes the whole pipeline while a data-memory access is outstanding; a timeout escalates to a halt.
- Keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before halting (1..255)
CNT_W, 16, width of performance counters

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-low (0 = reset)
start_i  in  1  level run enable; IDLE->RUN when 1
idex_memread_i  in  1  instruction in EX is a load
idex_rd_i  in  5  destination register of instruction in EX
ifid_rs1_i  in  5  rs1 of instruction in ID
ifid_rs2_i  in  5  rs2 of instruction in ID
branch_taken_i  in  1  branch resolved taken in ID this cycle
mem_req_i  in  1  MEM stage has a load/store this cycle
mem_ack_i  in  1  data memory completes access this cycle
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID write enable
ifid_flush_o  out  1  IF/ID clear to NOP
idex_noop_o  out  1  drives ID/EX NoOp_i (zero control signals)
freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB contents
halted_o  out  1  FSM in HALT (sticky until reset)
stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 while in RUN or MEM_WAIT
flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1

Behaviour:
- States: IDLE, RUN, MEM_WAIT, HALT.
- Reset (rst_i=0 at clock edge): state=IDLE, counters=0, wait counter=0. Reset overrides everything, including mid-MEM_WAIT and HALT.
- Control outputs are combinational from state and inputs, so they act in the same cycle. Counters and halted_o are registered.
- IDLE: pc_write_o=0, ifid_write_o=0, idex_noop_o=1, ifid_flush_o=0, freeze_o=0. Next state is RUN when start_i=1.
- RUN, default: pc_write_o=1, ifid_write_o=1, all other control outputs 0.
- RUN, priorities (highest first):
  1. Memory freeze. Condition: mem_req_i=1 and mem_ack_i=0. Outputs: freeze_o=1, pc_write_o=0, ifid_write_o=0, idex_noop_o=0, ifid_flush_o=0. Next state MEM_WAIT, wait counter loaded with 1. If mem_req_i=1 and mem_ack_i=1 in the same cycle, there is no freeze and the FSM stays in RUN.
  2. Load-use hazard. Condition: idex_memread_i=1, idex_rd_i!=0, and idex_rd_i equals ifid_rs1_i or ifid_rs2_i. Outputs: pc_write_o=0, ifid_write_o=0, idex_noop_o=1. ifid_flush_o is forced to 0 even if branch_taken_i=1, because the branch operands are not yet valid.
  3. Branch. Condition: branch_taken_i=1. Output: ifid_flush_o=1, with PC and IF/ID writes still enabled.
- MEM_WAIT, mem_ack_i=1: freeze_o=0 and normal RUN outputs that cycle (hazard and branch rules apply). Next state RUN.
- MEM_WAIT, mem_ack_i=0: same outputs as a freeze; wait counter increments.
  - If the wait counter equals MEM_TIMEOUT with no ack, next state is HALT.
  - start_i is ignored in MEM_WAIT.
- HALT: outputs as IDLE, with halted_o=1 from the cycle after entry. Exits only on reset.
- start_i=0 while in RUN: next state IDLE, unless a freeze is pending; a pending freeze completes in MEM_WAIT first.
- stall_cnt_o increments each cycle in RUN or MEM_WAIT where pc_write_o=0.
- flush_cnt_o increments each cycle where ifid_flush_o=1.
- Both counters saturate at 2^CNT_W-1; they do not wrap.

Test Plan:
- Reset/start: hold rst_i=0 for 2 cycles, then start_i=0 -> pc_write_o=0, idex_noop_o=1, counters 0. Raise start_i -> pc_write_o=1 next cycle.
- Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5 for 1 cycle -> pc_write_o=0, ifid_write_o=0, idex_noop_o=1 that cycle, stall_cnt_o=1.
- Load-use, rd=x0: same stimulus with idex_rd_i=0 -> no stall.
- Branch vs load-use: branch_taken_i=1 alone -> ifid_flush_o=1, flush_cnt_o=1. With a simultaneous load-use hazard -> ifid_flush_o=0, idex_noop_o=1.
- Memory freeze: mem_req_i=1, mem_ack_i=0 for 3 cycles, then ack -> freeze_o=1 for 3 cycles, 0 on the ack cycle, stall_cnt_o=3. A same-cycle req+ack -> no freeze.
- Timeout and reset: MEM_TIMEOUT=4, req with no ack -> HALT after 4 wait cycles, halted_o=1, pc_write_o=0 indefinitely. rst_i=0 for 1 cycle -> IDLE, halted_o=0, counters 0.
